// File: rtl/fiforeader_pkg.sv
// Shared types for the FIFO read-side adapter: occupancy encoding and buffer capacity.
package fiforeader_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } fiforeader_occ_t;

  localparam int FIFOREADER_CAP = 2;

  // Occupancy as a word count, so it can be summed with the in-flight flag.
  function automatic logic [1:0] occ_count(input fiforeader_occ_t occ);
    case (occ)
      ONE:     occ_count = 2'd1;
      TWO:     occ_count = 2'd2;
      default: occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fiforeader.sv
// Converts a registered-read FIFO dequeue port into a first-word-fall-through valid/ready stream.
// Optional delivered-word counter enabled by defining FIFOREADER_WORDCOUNT_EN.
module fiforeader
  import fiforeader_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef FIFOREADER_WORDCOUNT_EN
  , parameter int COUNTWIDTH = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifodata,
  output logic             deq,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
`ifdef FIFOREADER_WORDCOUNT_EN
  , output logic [COUNTWIDTH-1:0] wordcount
`endif
);

  fiforeader_occ_t  occ_q, occ_d;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;
  logic [1:0]       load;

  assign valid = (occ_q != ZERO);
  assign pop   = valid & ready;
  assign dout  = head_q;

  // Words buffered or in flight after this cycle's pop; fetch only while that leaves room.
  assign load = occ_count(occ_q) + {1'b0, inflight_q} - {1'b0, pop};
  assign deq  = !reset & !empty & (load < 2'(FIFOREADER_CAP));

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      ZERO: begin
        if (inflight_q) begin
          head_d = fifodata;
          occ_d  = ONE;
        end
      end
      ONE: begin
        if (inflight_q) begin
          if (pop) begin
            head_d = fifodata;
          end else begin
            tail_d = fifodata;
            occ_d  = TWO;
          end
        end else if (pop) begin
          occ_d = ZERO;
        end
      end
      TWO: begin
        // An arrival without a pop is impossible here because deq was withheld.
        if (pop) begin
          head_d = tail_q;
          if (inflight_q) begin
            tail_d = fifodata;
          end else begin
            occ_d = ONE;
          end
        end
      end
      default: occ_d = ZERO;
    endcase
  end

`ifdef FIFOREADER_WORDCOUNT_EN
  logic [COUNTWIDTH-1:0] wordcount_q, wordcount_d;

  assign wordcount_d = wordcount_q + {{(COUNTWIDTH-1){1'b0}}, pop};
  assign wordcount   = wordcount_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wordcount_q <= '0;
    end else begin
      wordcount_q <= wordcount_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q      <= ZERO;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= deq;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule
